// File: rtl/spi_byte_feeder.sv
// spi_byte_feeder: buffers {DC, byte} entries in a FIFO. It hands each byte
// to an 8-bit SPI transmitter with a one-cycle LOAD pulse, only when the
// transmitter is idle. After each transfer it inserts a programmable idle gap.
// DCX and SPI_IN change only on a pop, so both stay stable for a whole transfer.
module spi_byte_feeder #(
  parameter int DEPTH      = 16,  // FIFO entries, power of 2, >= 2
  parameter int GAP_CYCLES = 8    // idle clocks after BUSY falls; 0 = no gap
) (
  input  logic                     CLK_100MHz,
  input  logic                     RESET,
  input  logic                     WR_EN,
  input  logic [7:0]               WR_DATA,
  input  logic                     WR_DC,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     DRAINED,
  output logic                     SPI_LOAD,
  output logic [7:0]               SPI_IN,
  input  logic                     SPI_BUSY,
  output logic                     DCX
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  // Storage and FIFO bookkeeping
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  // Transmitter-facing registers
  logic          r_spi_load;
  logic [7:0]    r_spi_in;
  logic          r_dcx;
  logic [GW-1:0] r_gap_cnt;

  state_t        r_state;
  state_t        w_next_state;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_next;

  // A write while FULL is dropped even if a pop frees a slot on the same edge.
  assign w_push = WR_EN && !r_full;
  // A pop only starts from IDLE once the transmitter has finished any transfer.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !SPI_BUSY;

  // Occupancy after this edge, used for COUNT/FULL/EMPTY registers
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW + 1)'(1);
      2'b01:   w_count_next = r_count - (AW + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // FIFO array write port
  // NOTE: the storage array has no reset; pointers and COUNT define which entries are valid.
  always_ff @(posedge CLK_100MHz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {WR_DC, WR_DATA};
    end
  end

  // FIFO pointers, occupancy flags and sticky overflow
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (WR_EN && r_full) r_overflow <= 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_empty <= (w_count_next == '0);
    end
  end

  // Transmitter outputs: byte and DCX latch only on a pop, LOAD pulses for one cycle
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      r_spi_load <= 1'b0;
      r_spi_in   <= 8'h00;
      r_dcx      <= 1'b0;
    end else begin
      r_spi_load <= w_pop;
      if (w_pop) begin
        r_spi_in <= r_mem[r_rd_ptr][7:0];
        r_dcx    <= r_mem[r_rd_ptr][8];
      end
    end
  end

  // Gap counter: cleared while waiting for BUSY to fall, counts up during GAP
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_WAIT_DONE) begin
      r_gap_cnt <= '0;
    end else if (r_state == S_GAP) begin
      r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

  // State register
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic for the LOAD / wait / gap handshake
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (w_pop) w_next_state = S_LOAD;
      S_LOAD:       w_next_state = S_WAIT_START;
      S_WAIT_START: if (SPI_BUSY) w_next_state = S_WAIT_DONE;
      S_WAIT_DONE:  if (!SPI_BUSY) w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:        if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  assign FULL     = r_full;
  assign EMPTY    = r_empty;
  assign COUNT    = r_count;
  assign OVERFLOW = r_overflow;
  assign SPI_LOAD = r_spi_load;
  assign SPI_IN   = r_spi_in;
  assign DCX      = r_dcx;
  assign DRAINED  = r_empty && (r_state == S_IDLE) && !SPI_BUSY;

endmodule

// File: tb/tb_spi_byte_feeder.sv
// Directed testbench for spi_byte_feeder. It runs a GAP_CYCLES=8 instance
// against a behavioural transmitter, plus a GAP_CYCLES=0 instance for
// back-to-back timing.
module tb_spi_byte_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_dc;
  logic [7:0] wr_data;
  logic       full, empty, overflow, drained, spi_load, dcx, spi_busy;
  logic [4:0] count;
  logic [7:0] spi_in;

  logic       b_wr_en, b_wr_dc;
  logic [7:0] b_wr_data;
  logic       b_full, b_empty, b_overflow, b_drained, b_spi_load, b_dcx;
  logic [4:0] b_count;
  logic [7:0] b_spi_in;

  // Transmitter models
  logic tx_busy = 1'b0, hold_busy = 1'b0, b_tx_busy = 1'b0;
  int   tx_cnt = 0, tx_len = 20, b_tx_cnt = 0;
  assign spi_busy = tx_busy | hold_busy;

  // Monitor state
  int         cyc = 0, fall_cyc = 0, min_gap = 1000000, load_while_busy = 0;
  int         b_fall_cyc = 0, b_gap = 0, b_loads = 0;
  logic [8:0] load_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_byte_feeder #(.DEPTH(16), .GAP_CYCLES(8)) dut (
    .CLK_100MHz(clk), .RESET(reset), .WR_EN(wr_en), .WR_DATA(wr_data), .WR_DC(wr_dc),
    .FULL(full), .EMPTY(empty), .COUNT(count), .OVERFLOW(overflow), .DRAINED(drained),
    .SPI_LOAD(spi_load), .SPI_IN(spi_in), .SPI_BUSY(spi_busy), .DCX(dcx)
  );

  spi_byte_feeder #(.DEPTH(16), .GAP_CYCLES(0)) dut_nogap (
    .CLK_100MHz(clk), .RESET(reset), .WR_EN(b_wr_en), .WR_DATA(b_wr_data), .WR_DC(b_wr_dc),
    .FULL(b_full), .EMPTY(b_empty), .COUNT(b_count), .OVERFLOW(b_overflow), .DRAINED(b_drained),
    .SPI_LOAD(b_spi_load), .SPI_IN(b_spi_in), .SPI_BUSY(b_tx_busy), .DCX(b_dcx)
  );

  // Transmitter models (BUSY rises one cycle after sampling LOAD) and LOAD logging
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (spi_load) begin
      load_q.push_back({dcx, spi_in});
      if (spi_busy) load_while_busy = load_while_busy + 1;
      if (cyc - fall_cyc - 1 < min_gap) min_gap = cyc - fall_cyc - 1;
    end
    if (tx_busy) begin
      if (tx_cnt <= 1) begin
        tx_busy <= 1'b0;
        fall_cyc = cyc;
      end else begin
        tx_cnt <= tx_cnt - 1;
      end
    end else if (spi_load) begin
      tx_busy <= 1'b1;
      tx_cnt  <= tx_len;
    end
    if (b_spi_load) begin
      b_loads = b_loads + 1;
      b_gap   = cyc - b_fall_cyc - 1;
    end
    if (b_tx_busy) begin
      if (b_tx_cnt <= 1) begin
        b_tx_busy <= 1'b0;
        b_fall_cyc = cyc;
      end else begin
        b_tx_cnt <= b_tx_cnt - 1;
      end
    end else if (b_spi_load) begin
      b_tx_busy <= 1'b1;
      b_tx_cnt  <= 5;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one entry; call at a negedge, returns at the next negedge with WR_EN low
  task automatic push(input logic dc, input logic [7:0] data);
    wr_en = 1'b1; wr_dc = dc; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while (!drained && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(drained), 32'd1);
  endtask

  task automatic wait_busy(input logic level, input string tag, input int budget);
    int n = 0;
    while (spi_busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(spi_busy), 32'(level));
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_en = 1'b0; wr_dc = 1'b0; wr_data = 8'h00;
    b_wr_en = 1'b0; b_wr_dc = 1'b0; b_wr_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_load",     32'(spi_load), 32'd0);
    check("rst_spi_in",   32'(spi_in),   32'h00);
    check("rst_dcx",      32'(dcx),      32'd0);
    check("rst_drained",  32'(drained),  32'd1);
    check("rst_b_full_ovf_drained", 32'({b_full, b_overflow, b_drained}), 32'b001);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: latency, one-cycle LOAD, gap before DRAINED
    tx_len = 20;
    push(1'b0, 8'h2A);
    check("t1_count_after_push", 32'(count),    32'd1);
    check("t1_load_early",       32'(spi_load), 32'd0);
    @(negedge clk);
    check("t1_load_high",  32'(spi_load), 32'd1);
    check("t1_count_pop",  32'(count),    32'd0);
    check("t1_spi_in",     32'(spi_in),   32'h2A);
    check("t1_dcx",        32'(dcx),      32'd0);
    @(negedge clk);
    check("t1_load_low",   32'(spi_load), 32'd0);
    wait_busy(1'b1, "t1_busy_rise", 10);
    wait_busy(1'b0, "t1_busy_fall", 100);
    n = 0;
    while (!drained && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_drain_delay", 32'(n), 32'd9);
    check("t1_spi_in_hold", 32'(spi_in), 32'h2A);
    check("t1_dcx_hold",    32'(dcx),    32'd0);

    // Three bytes back-to-back with 1600-cycle transfers
    tx_len = 1600; load_q.delete(); min_gap = 1000000; load_while_busy = 0;
    push(1'b0, 8'h11);
    push(1'b1, 8'hA5);
    push(1'b1, 8'h3C);
    wait_drained("t2_drained", 8000);
    check("t2_nloads", 32'(load_q.size()), 32'd3);
    check("t2_load0",  32'(load_q[0]), 32'h011);
    check("t2_load1",  32'(load_q[1]), 32'h1A5);
    check("t2_load2",  32'(load_q[2]), 32'h13C);
    check("t2_min_gap", 32'(min_gap), 32'd10);
    check("t2_load_while_busy", 32'(load_while_busy), 32'd0);

    // Fill while BUSY held, overflow, then drain with pointer wrap
    tx_len = 20; load_q.delete(); hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(i[0], 8'(8'h40 + i));
    check("t3_full",     32'(full),     32'd1);
    check("t3_count16",  32'(count),    32'd16);
    check("t3_no_ovf",   32'(overflow), 32'd0);
    push(1'b1, 8'hFF);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count_kept", 32'(count),  32'd16);
    hold_busy = 1'b0;
    wait_drained("t3_drained", 2000);
    check("t3_nloads", 32'(load_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t3_load%0d", i), 32'(load_q[i]), 32'({i[0], 8'(8'h40 + i)}));

    // Simultaneous push and pop at COUNT=5
    load_q.delete(); hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'hB0 + i));
    check("t4_count5", 32'(count), 32'd5);
    wr_en = 1'b1; wr_dc = 1'b1; wr_data = 8'hC5; hold_busy = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    check("t4_count_same", 32'(count),    32'd5);
    check("t4_load",       32'(spi_load), 32'd1);
    check("t4_spi_in",     32'(spi_in),   32'hB0);
    wait_drained("t4_drained", 1000);
    check("t4_nloads", 32'(load_q.size()), 32'd6);
    for (int i = 0; i < 5; i++)
      check($sformatf("t4_load%0d", i), 32'(load_q[i]), 32'({1'b0, 8'(8'hB0 + i)}));
    check("t4_load5", 32'(load_q[5]), 32'h1C5);

    // Reset mid-transfer with 4 entries queued
    tx_len = 100; load_q.delete(); load_while_busy = 0;
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'hD0 + i));
    wait_busy(1'b1, "t5_busy", 20);
    check("t5_count4", 32'(count), 32'd4);
    reset = 1'b1;
    #1;
    check("t5_rst_count",    32'(count),    32'd0);
    check("t5_rst_empty",    32'(empty),    32'd1);
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    check("t5_rst_spi_in",   32'(spi_in),   32'h00);
    check("t5_rst_dcx",      32'(dcx),      32'd0);
    check("t5_rst_load",     32'(spi_load), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    load_q.delete();
    @(negedge clk);
    push(1'b1, 8'hE7);
    check("t5_count1", 32'(count),    32'd1);
    check("t5_no_load_busy", 32'(spi_load), 32'd0);
    wait_drained("t5_drained", 500);
    check("t5_nloads", 32'(load_q.size()), 32'd1);
    check("t5_load0",  32'(load_q[0]), 32'h1E7);
    check("t5_load_while_busy", 32'(load_while_busy), 32'd0);

    // GAP_CYCLES=0 instance: LOAD follows BUSY fall by 2 clocks
    b_wr_en = 1'b1; b_wr_dc = 1'b0; b_wr_data = 8'h5A;
    @(negedge clk);
    b_wr_dc = 1'b1; b_wr_data = 8'h6B;
    @(negedge clk);
    b_wr_en = 1'b0;
    n = 0;
    while (!b_drained && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_drained", 32'(b_drained), 32'd1);
    check("t6_nloads",  32'(b_loads),   32'd2);
    check("t6_gap",     32'(b_gap),     32'd2);
    check("t6_spi_in",  32'(b_spi_in),  32'h6B);
    check("t6_dcx",     32'(b_dcx),     32'd1);
    check("t6_count_empty", 32'({b_count, b_empty}), 32'({5'd0, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
